// File: rtl/pe_pkg.sv
// Shared PE widths and the load-stream command record latched by the address generator.
package pe_pkg;

  localparam int GLOBAL_MEM_ADDR_L = 16;
  localparam int REG_ADDR_L        = 5;
  localparam int LD_STREAM_CNT_L   = 8;
  localparam int LD_STRIDE_L       = 8;

  typedef struct packed {
    logic [GLOBAL_MEM_ADDR_L-1:0] mem_base;
    logic [LD_STRIDE_L-1:0]       mem_stride;
    logic [REG_ADDR_L-1:0]        reg_base;
    logic [LD_STREAM_CNT_L-1:0]   len;
  } ld_cmd_t;

endpackage

// File: rtl/pe_ld_stream_gen.sv
// Load-stream address generator: one command in, arm pulse, then one (mem, reg) pair per req/ack.
// Latency: arm 1 cycle after accept, first pair the cycle after; holds pairs while ack is low.
module pe_ld_stream_gen
  import pe_pkg::*;
#(
  parameter int MEM_ADDR_L = GLOBAL_MEM_ADDR_L,
  parameter int RADDR_L    = REG_ADDR_L,
  parameter int CNT_L      = LD_STREAM_CNT_L,
  parameter int STRIDE_L   = LD_STRIDE_L
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MEM_ADDR_L-1:0] cmd_mem_base,
  input  logic [STRIDE_L-1:0]   cmd_mem_stride,
  input  logic [RADDR_L-1:0]    cmd_reg_base,
  input  logic [CNT_L-1:0]      cmd_len,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  output logic [CNT_L-1:0]      ld_stream_len,
  output logic                  ld_stream_len_vld,
  output logic [MEM_ADDR_L-1:0] mem_addr_out,
  output logic [RADDR_L-1:0]    reg_addr_out,
  output logic                  mem_addr_req,
  input  logic                  mem_addr_ack,
  output logic                  busy,
  output logic                  done
);

  localparam int EXT_L = MEM_ADDR_L - STRIDE_L;

  typedef enum logic [1:0] {
    LD_IDLE   = 2'd0,
    LD_ARM    = 2'd1,
    LD_STREAM = 2'd2,
    LD_DONE   = 2'd3
  } ld_gen_state_t;

  ld_gen_state_t         state_q, state_d;
  ld_cmd_t               cmd_q;
  logic [MEM_ADDR_L-1:0] mem_addr_q;
  logic [RADDR_L-1:0]    reg_addr_q;
  logic [CNT_L-1:0]      remaining_q;
  logic [MEM_ADDR_L-1:0] stride_ext;
  logic                  cmd_take;
  logic                  pair_take;

  assign stride_ext = {{EXT_L{cmd_q.mem_stride[STRIDE_L-1]}}, cmd_q.mem_stride};
  assign cmd_take   = (state_q == LD_IDLE) && cmd_vld;
  assign pair_take  = (state_q == LD_STREAM) && mem_addr_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LD_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LD_IDLE:   if (cmd_vld) state_d = (cmd_len != '0) ? LD_ARM : LD_DONE;
      LD_ARM:    state_d = LD_STREAM;
      LD_STREAM: if (mem_addr_ack && (remaining_q == CNT_L'(1))) state_d = LD_DONE;
      LD_DONE:   state_d = LD_IDLE;
      default:   state_d = LD_IDLE;
    endcase
  end

  always_comb begin
    cmd_rdy           = 1'b0;
    ld_stream_len_vld = 1'b0;
    ld_stream_len     = '0;
    mem_addr_req      = 1'b0;
    done              = 1'b0;
    unique case (state_q)
      LD_IDLE:   cmd_rdy = 1'b1;
      LD_ARM: begin
        ld_stream_len_vld = 1'b1;
        ld_stream_len     = cmd_q.len;
      end
      LD_STREAM: mem_addr_req = 1'b1;
      LD_DONE:   done = 1'b1;
      default:   cmd_rdy = 1'b0;
    endcase
  end

  // Busy covers the accept cycle itself, hence the combinational cmd_vld term.
  assign busy         = (state_q != LD_IDLE) || cmd_vld;
  assign mem_addr_out = mem_addr_q;
  assign reg_addr_out = reg_addr_q;

  // Accumulators load during ARM, when the load unit cannot ack yet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q       <= '0;
      mem_addr_q  <= '0;
      reg_addr_q  <= '0;
      remaining_q <= '0;
    end else begin
      if (cmd_take) begin
        cmd_q.mem_base   <= cmd_mem_base;
        cmd_q.mem_stride <= cmd_mem_stride;
        cmd_q.reg_base   <= cmd_reg_base;
        cmd_q.len        <= cmd_len;
      end
      if (state_q == LD_ARM) begin
        mem_addr_q  <= cmd_q.mem_base;
        reg_addr_q  <= cmd_q.reg_base;
        remaining_q <= cmd_q.len;
      end else if (pair_take) begin
        mem_addr_q  <= mem_addr_q + stride_ext;
        reg_addr_q  <= reg_addr_q + RADDR_L'(1);
        remaining_q <= remaining_q - CNT_L'(1);
      end
    end
  end

  a_ack_needs_req: assert property (@(posedge clk) disable iff (!rst)
    mem_addr_ack |-> mem_addr_req);

  a_pair_held: assert property (@(posedge clk) disable iff (!rst)
    (mem_addr_req && !mem_addr_ack) |=>
      (mem_addr_req && $stable(mem_addr_out) && $stable(reg_addr_out)));

  a_done_pulse: assert property (@(posedge clk) disable iff (!rst)
    done |=> !done);

  a_no_arm_mid_stream: assert property (@(posedge clk) disable iff (!rst)
    ld_stream_len_vld |-> !mem_addr_req);

endmodule

// File: tb/tb_pe_ld_stream_gen.sv
// Randomized bench: expected pairs are computed as base + i*stride and reg_base + i, timing from
// the command/arm/stream/done sequence of each load command.
module tb_pe_ld_stream_gen;
  import pe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cmd_mem_base = '0;
  logic [7:0]  cmd_mem_stride = '0;
  logic [4:0]  cmd_reg_base = '0;
  logic [7:0]  cmd_len = '0;
  logic        cmd_vld = 1'b0;
  logic        cmd_rdy;
  logic [7:0]  ld_stream_len;
  logic        ld_stream_len_vld;
  logic [15:0] mem_addr_out;
  logic [4:0]  reg_addr_out;
  logic        mem_addr_req;
  logic        mem_addr_ack = 1'b0;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  pe_ld_stream_gen dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_mem_base      (cmd_mem_base),
    .cmd_mem_stride    (cmd_mem_stride),
    .cmd_reg_base      (cmd_reg_base),
    .cmd_len           (cmd_len),
    .cmd_vld           (cmd_vld),
    .cmd_rdy           (cmd_rdy),
    .ld_stream_len     (ld_stream_len),
    .ld_stream_len_vld (ld_stream_len_vld),
    .mem_addr_out      (mem_addr_out),
    .reg_addr_out      (reg_addr_out),
    .mem_addr_req      (mem_addr_req),
    .mem_addr_ack      (mem_addr_ack),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic reset_checks(input string pfx);
    check_val({pfx, "_rdy"},      32'(cmd_rdy), 32'd1);
    check_val({pfx, "_arm"},      32'(ld_stream_len_vld), 32'd0);
    check_val({pfx, "_len"},      32'(ld_stream_len), 32'd0);
    check_val({pfx, "_req"},      32'(mem_addr_req), 32'd0);
    check_val({pfx, "_mem"},      32'(mem_addr_out), 32'd0);
    check_val({pfx, "_reg"},      32'(reg_addr_out), 32'd0);
    check_val({pfx, "_busy"},     32'(busy), 32'd0);
    check_val({pfx, "_done"},     32'(done), 32'd0);
  endtask

  // ack_mode: k>0 acks on every k-th stream cycle, 0 acks at random.
  task automatic run_cmd(input logic [15:0] base, input logic [7:0] stride, input logic [4:0] rb,
                         input logic [7:0] len, input int ack_mode, input bit keep_vld,
                         input int rst_after);
    int i;
    int cyc;
    int s;
    bit a;
    logic [31:0] em;
    logic [4:0]  er;
    check_val("idle_rdy", 32'(cmd_rdy), 32'd1);
    cmd_mem_base   = base;
    cmd_mem_stride = stride;
    cmd_reg_base   = rb;
    cmd_len        = len;
    cmd_vld        = 1'b1;
    #1 check_val("busy_accept", 32'(busy), 32'd1);
    @(negedge clk);
    if (!keep_vld) cmd_vld = 1'b0;
    if (len == 8'd0) begin
      check_val("z_done",  32'(done), 32'd1);
      check_val("z_arm",   32'(ld_stream_len_vld), 32'd0);
      check_val("z_req",   32'(mem_addr_req), 32'd0);
      check_val("z_busy",  32'(busy), 32'd1);
      check_val("z_rdy",   32'(cmd_rdy), 32'd0);
      @(negedge clk);
      check_val("z_done_end", 32'(done), 32'd0);
      check_val("z_rdy_back", 32'(cmd_rdy), 32'd1);
      check_val("z_busy_end", 32'(busy), 32'(keep_vld));
      return;
    end
    check_val("arm_vld", 32'(ld_stream_len_vld), 32'd1);
    check_val("arm_len", 32'(ld_stream_len), 32'(len));
    check_val("arm_req", 32'(mem_addr_req), 32'd0);
    check_val("arm_done", 32'(done), 32'd0);
    check_val("arm_rdy", 32'(cmd_rdy), 32'd0);
    i = 0;
    cyc = 0;
    s = int'($signed(stride));
    while (i < int'(len)) begin
      @(negedge clk);
      mem_addr_ack = 1'b0;
      if (cyc > 1000) begin
        check_val("stream_budget", 32'(i), 32'(len));
        break;
      end
      if (rst_after == i) begin
        rst = 1'b0;
        cmd_vld = 1'b0;
        #1 reset_checks("midrst");
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      check_val("st_req",  32'(mem_addr_req), 32'd1);
      check_val("st_arm",  32'(ld_stream_len_vld), 32'd0);
      check_val("st_done", 32'(done), 32'd0);
      check_val("st_rdy",  32'(cmd_rdy), 32'd0);
      em = 32'(base) + 32'(i * s);
      er = rb + 5'(i);
      check_val("st_mem", 32'(mem_addr_out), {16'd0, em[15:0]});
      check_val("st_reg", 32'(reg_addr_out), 32'(er));
      if (ack_mode > 0) a = ((cyc % ack_mode) == (ack_mode - 1));
      else              a = ($urandom_range(0, 1) == 1);
      mem_addr_ack = a;
      if (a) i++;
      cyc++;
    end
    @(negedge clk);
    mem_addr_ack = 1'b0;
    check_val("dn_done", 32'(done), 32'd1);
    check_val("dn_req",  32'(mem_addr_req), 32'd0);
    check_val("dn_busy", 32'(busy), 32'd1);
    check_val("dn_rdy",  32'(cmd_rdy), 32'd0);
    check_val("dn_arm",  32'(ld_stream_len_vld), 32'd0);
    @(negedge clk);
    check_val("dn_done_end", 32'(done), 32'd0);
    check_val("dn_rdy_back", 32'(cmd_rdy), 32'd1);
    check_val("dn_busy_end", 32'(busy), 32'(keep_vld));
  endtask

  initial begin
    #1 reset_checks("rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_cmd(16'h0100, 8'd4, 5'd3, 8'd4, 1, 1'b0, -1);
    run_cmd(16'h0100, 8'd4, 5'd3, 8'd4, 3, 1'b0, -1);
    run_cmd(16'h0100, 8'd4, 5'd3, 8'd0, 1, 1'b0, -1);
    run_cmd(16'h0004, 8'hFC, 5'd30, 8'd3, 1, 1'b0, -1);
    run_cmd(16'h0200, 8'd0, 5'd7, 8'd3, 2, 1'b0, -1);
    run_cmd(16'h0300, 8'd2, 5'd1, 8'd3, 1, 1'b1, -1);
    run_cmd(16'h0300, 8'd2, 5'd1, 8'd3, 1, 1'b0, -1);
    run_cmd(16'h0400, 8'd8, 5'd9, 8'd5, 1, 1'b0, 2);
    run_cmd(16'h0A00, 8'd1, 5'd20, 8'd2, 1, 1'b0, -1);

    for (int n = 0; n < 30; n++) begin
      run_cmd(16'($urandom), 8'($urandom), 5'($urandom), 8'($urandom_range(0, 10)),
              int'($urandom_range(0, 3)), 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1);
  end

endmodule
